// File: rtl/cvw.sv
// Core configuration record; only the floating-point field widths are needed here.
package cvw;

   typedef struct packed {
      int unsigned NE;
      int unsigned NF;
   } cvw_t;

   localparam cvw_t DoubleCfg = '{NE: 11, NF: 52};

endpackage

// File: rtl/divsqrt_prenorm.sv
// Divide/sqrt operand pre-normalizer: left-justifies subnormal significands over
// one or two cycles, then predicts the biased quotient/root exponent.
module divsqrt_prenorm import cvw::*; #(
   parameter cvw_t P = DoubleCfg
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Flush,
   input  logic               InValid,
   output logic               InReady,
   input  logic               SqrtE,
   input  logic [P.NE-1:0]    Xe,
   input  logic [P.NE-1:0]    Ye,
   input  logic [P.NF:0]      Xm,
   input  logic [P.NF:0]      Ym,
   output logic               OutValid,
   input  logic               OutReady,
   output logic [P.NF:0]      PreXm,
   output logic [P.NF:0]      PreYm,
   output logic [P.NE+1:0]    PreQe,
   output logic               PreSqrtOdd,
   output logic               PreZero
);

   localparam int NE  = P.NE;
   localparam int NF  = P.NF;
   localparam int EW  = NE + 2;
   localparam int LzW = $clog2(NF + 2);
   localparam logic [EW-1:0] Bias = EW'((1 << (NE - 1)) - 1);

   typedef enum logic [2:0] {StIdle, StNormX, StNormY, StExp, StDone} statetype;

   statetype       state, nextState;
   logic           sqrtQ;
   logic [EW-1:0]  XeEff, YeEff;
   logic [LzW-1:0] lzX, lzY;
   logic [EW-1:0]  u, uHalf;
   logic           zero;

   function automatic logic [LzW-1:0] lzc(input logic [NF:0] m);
      lzc = LzW'(NF + 1);
      for (int i = 0; i <= NF; i++) begin
         if (m[i]) lzc = LzW'(NF - i);
      end
   endfunction

   assign lzX = lzc(PreXm);
   assign lzY = lzc(PreYm);

   // Unbiased sqrt exponent; (u - u[0]) >>> 1 is floor(u/2), i.e. u arithmetically shifted.
   assign u     = XeEff - Bias;
   assign uHalf = {u[EW-1], u[EW-1:1]};
   assign zero  = (PreXm == '0) || (!sqrtQ && (PreYm == '0));

   always_ff @(posedge clk) begin
      if (reset) state <= StIdle;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      InReady   = (state == StIdle);
      OutValid  = (state == StDone);
      if (Flush) begin
         nextState = StIdle;
      end else begin
         unique case (state)
            StIdle:  if (InValid) nextState = StNormX;
            StNormX: nextState = sqrtQ ? StExp : StNormY;
            StNormY: nextState = StExp;
            StExp:   nextState = StDone;
            StDone:  if (OutReady) nextState = StIdle;
            default: nextState = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sqrtQ      <= 1'b0;
         XeEff      <= '0;
         YeEff      <= '0;
         PreXm      <= '0;
         PreYm      <= '0;
         PreQe      <= '0;
         PreSqrtOdd <= 1'b0;
         PreZero    <= 1'b0;
      end else if (Flush) begin
         PreZero <= 1'b0;
      end else begin
         case (state)
            StIdle: if (InValid) begin
               sqrtQ <= SqrtE;
               PreXm <= Xm;
               XeEff <= (Xe == '0) ? EW'(1) : EW'(Xe);
               YeEff <= (Ye == '0) ? EW'(1) : EW'(Ye);
               // PreYm keeps its last value across square roots.
               if (!SqrtE) PreYm <= Ym;
            end
            StNormX: begin
               PreXm <= PreXm << lzX;
               XeEff <= XeEff - EW'(lzX);
            end
            StNormY: begin
               PreYm <= PreYm << lzY;
               YeEff <= YeEff - EW'(lzY);
            end
            StExp: begin
               PreZero    <= zero;
               PreSqrtOdd <= sqrtQ & ~zero & u[0];
               if (zero)       PreQe <= '0;
               else if (sqrtQ) PreQe <= uHalf + Bias;
               else            PreQe <= XeEff - YeEff + Bias;
            end
            default: ;
         endcase
      end
   end

endmodule
